// File: rtl/debounced_updown_counter_pkg.sv
// -----------------------------------------------------------------------------
// debounced_updown_counter_pkg
//   Shared types and helpers for the debounced up/down counter.
//   - db_state_e     : accepted (debounced) level of one button channel
//   - cnt_op_e       : resolved per-cycle action on the count register
//   - released_level : raw pin level that means "not pressed"
//   - decode_op      : resolves clr / inc / dec strobes into one action
// -----------------------------------------------------------------------------
package debounced_updown_counter_pkg;

    typedef enum logic {
        DB_RELEASED = 1'b0,
        DB_PRESSED  = 1'b1
    } db_state_e;

    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_INC   = 2'd1,
        CNT_DEC   = 2'd2,
        CNT_CLEAR = 2'd3
    } cnt_op_e;

    // An active-low button idles high, an active-high button idles low.
    function automatic logic released_level(input int active_low);
        return (active_low != 0);
    endfunction

    // clr wins over the strobes; simultaneous inc and dec cancel out.
    function automatic cnt_op_e decode_op(input logic clr,
                                          input logic inc,
                                          input logic dec);
        cnt_op_e op;
        if (clr)
            op = CNT_CLEAR;
        else if (inc && !dec)
            op = CNT_INC;
        else if (dec && !inc)
            op = CNT_DEC;
        else
            op = CNT_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/debounced_updown_counter_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   One button channel: 2-FF synchroniser, debounce counter and a registered
//   one-cycle strobe for each accepted press.
//
//   Ports
//     clk         in   system clock, rising edge
//     rst         in   synchronous active-high reset
//     btn_raw     in   raw asynchronous button pin
//     pressed     out  accepted (debounced) level, 1 = pressed
//     press_pulse out  1 for one cycle after the accepted level goes 0->1
//
//   A synchronised level that differs from the accepted one must persist for
//   DEBOUNCE_CYCLES consecutive cycles before it is accepted; any return to
//   the accepted level restarts the run from zero.
// -----------------------------------------------------------------------------
module button_debounce
    import debounced_updown_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pressed,
    output logic press_pulse
);

    localparam int   CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic REL   = released_level(ACTIVE_LOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             sampled_pressed;
    logic             disagree;

    assign sampled_pressed = s2_q ^ REL;
    assign disagree        = sampled_pressed != (state_q == DB_PRESSED);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= REL;
            s2_q    <= REL;
            state_q <= DB_RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            pulse_q <= 1'b0;
            if (!disagree) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // Accept the new level; only the release->press flip strobes.
                cnt_q   <= '0;
                state_q <= sampled_pressed ? DB_PRESSED : DB_RELEASED;
                pulse_q <= sampled_pressed;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pressed     = (state_q == DB_PRESSED);
    assign press_pulse = pulse_q;

endmodule

// File: rtl/debounced_updown_counter.sv
// -----------------------------------------------------------------------------
// debounced_updown_counter
//   Up/down counter driven by two raw buttons, each debounced in the clk
//   domain; one count step per accepted press. Wraps or saturates.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset
//     clr        in   synchronous clear of the count (not debounced)
//     btn_inc    in   raw increment button
//     btn_dec    in   raw decrement button
//     count      out  current count (LEDs)
//     inc_pulse  out  one-cycle strobe per accepted increment press
//     dec_pulse  out  one-cycle strobe per accepted decrement press
//     at_max     out  count == 2^WIDTH-1
//     at_min     out  count == 0
// -----------------------------------------------------------------------------
module debounced_updown_counter
    import debounced_updown_counter_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int SATURATE        = 0,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             btn_inc,
    input  logic             btn_dec,
    output logic [WIDTH-1:0] count,
    output logic             inc_pulse,
    output logic             dec_pulse,
    output logic             at_max,
    output logic             at_min
);

    localparam logic CLAMP = (SATURATE != 0);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             inc_level;
    logic             dec_level;
    logic             unused_levels;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_inc (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_inc),
        .pressed     (inc_level),
        .press_pulse (inc_pulse)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_dec (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_dec),
        .pressed     (dec_level),
        .press_pulse (dec_pulse)
    );

    // Debounced levels are not needed here; only the press strobes count.
    assign unused_levels = inc_level ^ dec_level;

    assign at_max = (count_q == {WIDTH{1'b1}});
    assign at_min = (count_q == '0);

    always_comb begin
        count_d = count_q;
        unique case (decode_op(clr, inc_pulse, dec_pulse))
            CNT_CLEAR: count_d = '0;
            CNT_INC:   if (!(CLAMP && at_max)) count_d = count_q + WIDTH'(1);
            CNT_DEC:   if (!(CLAMP && at_min)) count_d = count_q - WIDTH'(1);
            default:   count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: doc/debounced_updown_counter.md
Name: debounced_updown_counter

Overview:
Parametrised successor to the single-button LED counter. Raw active-low pmod buttons are synchronised and debounced inside the block, and one press is counted per debounced press instead of per raw edge. The count goes up or down on two buttons, can wrap or saturate, and is driven onto LEDs. The whole block runs in the system clock domain instead of using buttons as clocks.

Parameters:
WIDTH, 4, count width in bits (≥1).
DEBOUNCE_CYCLES, 120000, consecutive stable cycles before a level change is accepted (10 ms at 12 MHz); must be ≥2.
SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at 0 and 2^WIDTH-1.
BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
clr  input  1  synchronous clear of count; already in clk domain, not debounced.
btn_inc  input  1  raw, asynchronous increment button.
btn_dec  input  1  raw, asynchronous decrement button.
count  output  WIDTH  current count (drives LEDs).
inc_pulse  output  1  one-cycle strobe per accepted increment press.
dec_pulse  output  1  one-cycle strobe per accepted decrement press.
at_max  output  1  count == 2^WIDTH-1.
at_min  output  1  count == 0.

Behaviour:
- Reset (rst=1 at a clk edge) sets the following:
  - count=0 and inc_pulse=dec_pulse=0.
  - Sync flops are loaded with the released level.
  - Debounce state = released and debounce counters = 0.
  - at_min=1 and at_max=0 (at_max=1 only if WIDTH makes max=0, which is impossible since WIDTH≥1).
- Per button channel:
  - 2-FF synchroniser: s1<=raw, s2<=s1. Define pressed = s2 XOR BTN_ACTIVE_LOW.
  - Debounce counter width is clog2(DEBOUNCE_CYCLES).
  - If pressed==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=pressed, cnt<=0.
  - Else cnt<=cnt+1.
  - Press pulse is registered. It is 1 for exactly the one cycle after the edge where stable goes 0→1. Release (1→0) produces no pulse.
  - A disagreement shorter than DEBOUNCE_CYCLES cycles is rejected with no state change, and the counter restarts from 0 on each bounce.
- Latency: the raw press is first sampled by s1 at edge k.
  - stable flips and the pulse register is set at edge k+1+DEBOUNCE_CYCLES.
  - count updates at edge k+2+DEBOUNCE_CYCLES.
- Count update priority per edge: rst > clr > pulses.
  - inc_pulse and dec_pulse both 1 in the same cycle: count unchanged.
  - inc only: count+1. Wraps to 0 if SATURATE=0; holds at max if SATURATE=1.
  - dec only: count-1. Wraps to max if SATURATE=0; holds at 0 if SATURATE=1.
  - Pulses are still emitted when saturated.
- clr does not affect debounce state: a press in progress still completes and counts after clr.
- Holding a button produces exactly one pulse; the next pulse needs a debounced release followed by a debounced press.
- A button held through reset is seen as a new press after rst deasserts: one pulse at the normal latency.
- at_max and at_min are decoded combinationally from the count register, with no extra latency.

Decomposition:
- No shared package required. The released level is derived locally from BTN_ACTIVE_LOW.
- Sub-module button_debounce (params DEBOUNCE_CYCLES, ACTIVE_LOW; ports clk, rst, btn_raw, pressed, press_pulse) contains the synchroniser, debounce counter and edge pulse.
- It is instantiated twice; the top holds the count register and the wrap/saturate logic.

Test Plan:
- WIDTH=4, N=4, wrap. Reset, then btn_inc low from edge k, held → inc_pulse=1 after edge k+5; count 0→1 after edge k+6; no further pulse while held.
- Bounce rejection. btn_inc low for 3 cycles, high 1 cycle, repeated 5 times, then high → no inc_pulse, count stays 0.
- Wrap. 16 inc presses from 0 → count=0 and at_min=1. Then one dec press → count=15 and at_max=1.
- SATURATE=1. At 15, inc press → inc_pulse=1, count stays 15. At 0, dec press → dec_pulse=1, count stays 0.
- Simultaneous. Both buttons pressed on the same cycle, count=7 → both pulses on the same cycle, count stays 7.
- Reset/clear mid-operation:
  - rst asserted mid-debounce (cnt=2) → no pulse; count=0.
  - Button held across rst deassert → exactly one pulse at the normal latency.
  - clr=1 at count=9 while an inc press is debouncing → count=0, then 1 after the pulse.
